// File: rtl/posit_result_checker_if.sv
// ============================================================================
//  Module      : posit_result_checker_if
//  Description : Operand/result stream and statistics bundle for the posit
//                result checker. The slave side is the checker itself; the
//                master side drives the stream and reads back statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface posit_result_checker_if #(
  parameter int N     = 32,
  parameter int CNT_W = 32
);
  // Control and stream inputs
  logic             start;
  logic             stop;
  logic             in_valid;
  logic [N-1:0]     exp_value;
  logic [N-1:0]     dut_result;
  logic             dut_done;
  // Status and statistics outputs
  logic             busy;
  logic             finished;
  logic             diff_valid;
  logic [N-1:0]     diff_out;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [N-1:0]     max_diff;
  logic             fail;
  logic             proto_err;
  logic [CNT_W-1:0] first_idx;
  logic [N-1:0]     first_res;
  logic [N-1:0]     first_exp;

  modport master (
    output start, stop, in_valid, exp_value, dut_result, dut_done,
    input  busy, finished, diff_valid, diff_out, sample_cnt, err_cnt,
           max_diff, fail, proto_err, first_idx, first_res, first_exp
  );

  modport slave (
    input  start, stop, in_valid, exp_value, dut_result, dut_done,
    output busy, finished, diff_valid, diff_out, sample_cnt, err_cnt,
           max_diff, fail, proto_err, first_idx, first_res, first_exp
  );
endinterface

`default_nettype wire

// File: rtl/posit_result_checker.sv
// ============================================================================
//  Module      : posit_result_checker
//  Description : Scoreboard for a pipelined posit unit. Expected values are
//                delayed by the unit latency and compared against the unit's
//                result; error statistics and the first mismatch are kept.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module posit_result_checker #(
  parameter int N       = 32,
  parameter int LATENCY = 4,
  parameter int TOL     = 0,
  parameter int CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  posit_result_checker_if.slave bus
);

  localparam logic [N-1:0] C_NAR = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] C_TOL = N'(TOL);
  localparam int           C_DW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [C_DW-1:0]   r_drain_cnt;
  logic              r_busy;
  logic              r_finished;

  logic [LATENCY-1:0] r_dl_vld;
  logic [N-1:0]       r_dl_exp [LATENCY];

  logic              r_diff_valid;
  logic [N-1:0]      r_diff_out;
  logic [CNT_W-1:0]  r_sample_cnt;
  logic [CNT_W-1:0]  r_err_cnt;
  logic [N-1:0]      r_max_diff;
  logic              r_fail;
  logic              r_proto_err;
  logic [CNT_W-1:0]  r_first_idx;
  logic [N-1:0]      r_first_res;
  logic [N-1:0]      r_first_exp;

  logic              w_active;
  logic              w_load_vld;
  logic              w_dv;
  logic [N-1:0]      w_exp;
  logic              w_cmp;
  logic              w_exp_nar;
  logic              w_res_nar;
  logic [N-1:0]      w_diff;
  logic              w_err;

  assign w_active   = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_load_vld = bus.in_valid && (r_state == S_RUN);
  assign w_dv       = r_dl_vld[LATENCY-1];
  assign w_exp      = r_dl_exp[LATENCY-1];
  assign w_cmp      = w_dv && w_active;
  assign w_exp_nar  = (w_exp == C_NAR);
  assign w_res_nar  = (bus.dut_result == C_NAR);
  assign w_err      = (w_diff > C_TOL);

  // Control FSM; DRAIN holds for exactly LATENCY cycles so the last issued sample is compared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= '0;
      r_busy      <= 1'b0;
      r_finished  <= 1'b0;
    end else if (bus.start) begin
      r_state     <= S_RUN;
      r_drain_cnt <= '0;
      r_busy      <= 1'b1;
      r_finished  <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (bus.stop) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= C_DW'(LATENCY - 1);
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == '0) begin
            r_state    <= S_DONE;
            r_busy     <= 1'b0;
            r_finished <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Expected-value delay line matching the unit latency; only RUN issues new samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dl_vld <= '0;
      for (int i = 0; i < LATENCY; i++) r_dl_exp[i] <= '0;
    end else if (bus.start) begin
      r_dl_vld <= '0;
      for (int i = 0; i < LATENCY; i++) r_dl_exp[i] <= '0;
    end else begin
      r_dl_vld[0] <= w_load_vld;
      r_dl_exp[0] <= bus.exp_value;
      for (int i = 1; i < LATENCY; i++) begin
        r_dl_vld[i] <= r_dl_vld[i-1];
        r_dl_exp[i] <= r_dl_exp[i-1];
      end
    end
  end

  // Absolute bit-pattern distance; NaR only matches NaR and is maximally far from anything else
  always_comb begin
    w_diff = '0;
    if (w_exp_nar && w_res_nar) begin
      w_diff = '0;
    end else if (w_exp_nar || w_res_nar) begin
      w_diff = '1;
    end else if (w_exp > bus.dut_result) begin
      w_diff = w_exp - bus.dut_result;
    end else begin
      w_diff = bus.dut_result - w_exp;
    end
  end

  // Statistics: saturating counters, running maximum, sticky flags and first-mismatch capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_diff_valid <= 1'b0;
      r_diff_out   <= '0;
      r_sample_cnt <= '0;
      r_err_cnt    <= '0;
      r_max_diff   <= '0;
      r_fail       <= 1'b0;
      r_proto_err  <= 1'b0;
      r_first_idx  <= '0;
      r_first_res  <= '0;
      r_first_exp  <= '0;
    end else if (bus.start) begin
      r_diff_valid <= 1'b0;
      r_diff_out   <= '0;
      r_sample_cnt <= '0;
      r_err_cnt    <= '0;
      r_max_diff   <= '0;
      r_fail       <= 1'b0;
      r_proto_err  <= 1'b0;
      r_first_idx  <= '0;
      r_first_res  <= '0;
      r_first_exp  <= '0;
    end else begin
      r_diff_valid <= w_cmp;
      if (w_cmp) begin
        r_diff_out <= w_diff;
        if (!(&r_sample_cnt)) r_sample_cnt <= r_sample_cnt + 1'b1;
        if (w_diff > r_max_diff) r_max_diff <= w_diff;
        if (w_err) begin
          r_fail <= 1'b1;
          if (!(&r_err_cnt)) r_err_cnt <= r_err_cnt + 1'b1;
          // err_cnt never wraps, so zero means no mismatch has been captured yet
          if (r_err_cnt == '0) begin
            r_first_idx <= r_sample_cnt;
            r_first_res <= bus.dut_result;
            r_first_exp <= w_exp;
          end
        end
      end
      if (w_active && (bus.dut_done != w_dv)) begin
        r_proto_err <= 1'b1;
        r_fail      <= 1'b1;
      end
    end
  end

  assign bus.busy       = r_busy;
  assign bus.finished   = r_finished;
  assign bus.diff_valid = r_diff_valid;
  assign bus.diff_out   = r_diff_out;
  assign bus.sample_cnt = r_sample_cnt;
  assign bus.err_cnt    = r_err_cnt;
  assign bus.max_diff   = r_max_diff;
  assign bus.fail       = r_fail;
  assign bus.proto_err  = r_proto_err;
  assign bus.first_idx  = r_first_idx;
  assign bus.first_res  = r_first_res;
  assign bus.first_exp  = r_first_exp;

endmodule

`default_nettype wire

// File: tb/tb_posit_result_checker.sv
// ============================================================================
//  Module      : tb_posit_result_checker
//  Description : Self-checking bench for posit_result_checker. Emulates the
//                posit unit with per-cycle done/result schedules and checks
//                statistics against a sample-list scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_posit_result_checker;

  localparam int          N    = 32;
  localparam int          L    = 4;
  localparam int          TOL  = 0;
  localparam int          CW   = 32;
  localparam logic [31:0] NAR  = 32'h8000_0000;
  localparam int          MAXC = 256;

  logic clk = 1'b0;
  logic rst_n;

  posit_result_checker_if #(.N(N), .CNT_W(CW)) bus ();

  posit_result_checker #(.N(N), .LATENCY(L), .TOL(TOL), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  // Per-sample stimulus (indexed by issue cycle) and per-cycle unit outputs
  bit          vv       [MAXC];
  logic [31:0] ee       [MAXC];
  logic [31:0] rr       [MAXC];
  bit          drv_done [MAXC];
  logic [31:0] drv_res  [MAXC];

  typedef struct {
    logic [31:0] e;
    logic [31:0] r;
    logic [31:0] d;
    int          errs;
  } vec_t;

  vec_t tbl [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_diff(input logic [31:0] a, input logic [31:0] b);
    longint la = longint'(a);
    longint lb = longint'(b);
    if (a == NAR || b == NAR) return (a == b) ? 32'h0 : 32'hFFFF_FFFF;
    return 32'((la > lb) ? (la - lb) : (lb - la));
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"},       64'(bus.busy),       64'd0);
    chk({tag, " finished"},   64'(bus.finished),   64'd0);
    chk({tag, " diff_valid"}, 64'(bus.diff_valid), 64'd0);
    chk({tag, " diff_out"},   64'(bus.diff_out),   64'd0);
    chk({tag, " sample_cnt"}, 64'(bus.sample_cnt), 64'd0);
    chk({tag, " err_cnt"},    64'(bus.err_cnt),    64'd0);
    chk({tag, " max_diff"},   64'(bus.max_diff),   64'd0);
    chk({tag, " fail"},       64'(bus.fail),       64'd0);
    chk({tag, " proto_err"},  64'(bus.proto_err),  64'd0);
    chk({tag, " first_idx"},  64'(bus.first_idx),  64'd0);
    chk({tag, " first_res"},  64'(bus.first_res),  64'd0);
    chk({tag, " first_exp"},  64'(bus.first_exp),  64'd0);
  endtask

  // Pulse start, stream n issue cycles with a unit of latency lat, optionally stop and check
  task automatic run_seq(input int n, input int lat, input bit partial, input string tag);
    int          last;
    int          cnt;
    int          errs;
    logic [31:0] mx, fi, fr, fe, d;
    bit          pe;
    bit          want;

    bus.start = 1'b1; bus.stop = 1'b0; bus.in_valid = 1'b0; bus.dut_done = 1'b0;
    tick();
    bus.start = 1'b0;

    last = partial ? n + 1 : n + L + 1;
    for (int c = 0; c <= last; c++) begin
      if (c - lat >= 0 && c - lat < n && vv[c-lat]) begin
        drv_done[c] = 1'b1;
        drv_res[c]  = rr[c-lat];
      end else begin
        drv_done[c] = 1'b0;
        drv_res[c]  = $urandom;
      end
    end

    for (int c = 0; c <= last; c++) begin
      want = (c - L - 1 >= 0) && (c - L - 1 < n) && vv[c-L-1];
      chk($sformatf("%s diff_valid c%0d", tag, c), 64'(bus.diff_valid), 64'(want));
      if (want)
        chk($sformatf("%s diff_out c%0d", tag, c), 64'(bus.diff_out),
            64'(ref_diff(ee[c-L-1], drv_res[c-1])));
      if (!partial && c == n + L) begin
        chk({tag, " busy in drain"},      64'(bus.busy),     64'd1);
        chk({tag, " finished in drain"},  64'(bus.finished), 64'd0);
      end
      if (!partial && c == n + L + 1) begin
        chk({tag, " busy after drain"},     64'(bus.busy),     64'd0);
        chk({tag, " finished after drain"}, 64'(bus.finished), 64'd1);
      end
      bus.in_valid   = (c < n) ? vv[c] : 1'b0;
      bus.exp_value  = (c < n) ? ee[c] : $urandom;
      bus.stop       = (!partial && c == n);
      bus.dut_done   = drv_done[c];
      bus.dut_result = drv_res[c];
      tick();
    end
    bus.in_valid = 1'b0; bus.stop = 1'b0; bus.dut_done = 1'b0;

    if (!partial) begin
      // Scoreboard: each issued sample meets whatever result is on the bus L cycles later
      cnt = 0; errs = 0; mx = '0; fi = '0; fr = '0; fe = '0; pe = 1'b0;
      for (int i = 0; i < n; i++) begin
        if (vv[i]) begin
          d = ref_diff(ee[i], drv_res[i+L]);
          if (d > 32'(TOL)) begin
            if (errs == 0) begin fi = 32'(cnt); fr = drv_res[i+L]; fe = ee[i]; end
            errs++;
          end
          if (d > mx) mx = d;
          cnt++;
        end
      end
      for (int c = 0; c <= n + L; c++)
        if (drv_done[c] != ((c - L >= 0) && (c - L < n) && vv[c-L])) pe = 1'b1;
      chk({tag, " sample_cnt"}, 64'(bus.sample_cnt), 64'(cnt));
      chk({tag, " err_cnt"},    64'(bus.err_cnt),    64'(errs));
      chk({tag, " max_diff"},   64'(bus.max_diff),   64'(mx));
      chk({tag, " proto_err"},  64'(bus.proto_err),  64'(pe));
      chk({tag, " fail"},       64'(bus.fail),       64'((errs != 0) || pe));
      chk({tag, " first_idx"},  64'(bus.first_idx),  64'(fi));
      chk({tag, " first_res"},  64'(bus.first_res),  64'(fr));
      chk({tag, " first_exp"},  64'(bus.first_exp),  64'(fe));
    end
  endtask

  // Bound on total run time
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.in_valid = 1'b0;
    bus.exp_value = '0; bus.dut_result = '0; bus.dut_done = 1'b0;
    rst_n = 1'b0;

    tbl[0] = '{32'h4000_0000, 32'h4000_0003, 32'h0000_0003, 1};
    tbl[1] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 0};
    tbl[2] = '{32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1};
    tbl[3] = '{32'h1234_5678, 32'h8000_0000, 32'hFFFF_FFFF, 1};
    tbl[4] = '{32'h0000_0001, 32'h7FFF_FFFF, 32'h7FFF_FFFE, 1};
    tbl[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1};
    tbl[6] = '{32'h3C00_0000, 32'h3C00_0000, 32'h0000_0000, 0};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // 100 matching samples; finished exactly L cycles into the drain
    for (int i = 0; i < 100; i++) begin vv[i] = 1'b1; ee[i] = $urandom; rr[i] = ee[i]; end
    run_seq(100, L, 1'b0, "clean100");
    chk("clean100 const sample_cnt", 64'(bus.sample_cnt), 64'd100);
    chk("clean100 const err_cnt",    64'(bus.err_cnt),    64'd0);
    chk("clean100 const fail",       64'(bus.fail),       64'd0);

    // Single-sample comparator table
    foreach (tbl[k]) begin
      vv[0] = 1'b1; ee[0] = tbl[k].e; rr[0] = tbl[k].r;
      run_seq(1, L, 1'b0, $sformatf("tbl%0d", k));
      chk($sformatf("tbl%0d diff_out", k),   64'(bus.diff_out),   64'(tbl[k].d));
      chk($sformatf("tbl%0d max_diff", k),   64'(bus.max_diff),   64'(tbl[k].d));
      chk($sformatf("tbl%0d err_cnt", k),    64'(bus.err_cnt),    64'(tbl[k].errs));
      chk($sformatf("tbl%0d sample_cnt", k), 64'(bus.sample_cnt), 64'd1);
    end

    // First mismatch at sample 7
    for (int i = 0; i < 20; i++) begin vv[i] = 1'b1; ee[i] = $urandom; rr[i] = ee[i]; end
    ee[7] = 32'h4000_0000; rr[7] = 32'h4000_0003;
    run_seq(20, L, 1'b0, "mis7");
    chk("mis7 err_cnt",   64'(bus.err_cnt),   64'd1);
    chk("mis7 first_idx", 64'(bus.first_idx), 64'd7);
    chk("mis7 first_res", 64'(bus.first_res), 64'h4000_0003);
    chk("mis7 first_exp", 64'(bus.first_exp), 64'h4000_0000);
    chk("mis7 max_diff",  64'(bus.max_diff),  64'd3);

    // NaR against NaR, then NaR against zero
    vv[0] = 1'b1; ee[0] = NAR; rr[0] = NAR;
    vv[1] = 1'b1; ee[1] = NAR; rr[1] = 32'h0;
    run_seq(2, L, 1'b0, "nar2");
    chk("nar2 err_cnt",   64'(bus.err_cnt),   64'd1);
    chk("nar2 first_idx", 64'(bus.first_idx), 64'd1);
    chk("nar2 max_diff",  64'(bus.max_diff),  64'hFFFF_FFFF);

    // Unit one cycle early
    for (int i = 0; i < 20; i++) begin vv[i] = 1'b1; ee[i] = $urandom; rr[i] = ee[i]; end
    run_seq(20, L - 1, 1'b0, "early");
    chk("early proto_err", 64'(bus.proto_err), 64'd1);
    chk("early fail",      64'(bus.fail),      64'd1);

    // start mid-RUN after 10 samples with errors, then 5 clean samples
    for (int i = 0; i < 10; i++) begin vv[i] = 1'b1; ee[i] = $urandom; rr[i] = ee[i]; end
    rr[0] = ee[0] ^ 32'h10;
    run_seq(10, L, 1'b1, "pre");
    chk("pre fail set", 64'(bus.fail), 64'd1);
    for (int i = 0; i < 5; i++) begin vv[i] = 1'b1; ee[i] = $urandom; rr[i] = ee[i]; end
    run_seq(5, L, 1'b0, "restart");
    chk("restart sample_cnt", 64'(bus.sample_cnt), 64'd5);
    chk("restart err_cnt",    64'(bus.err_cnt),    64'd0);
    chk("restart fail",       64'(bus.fail),       64'd0);
    chk("restart proto_err",  64'(bus.proto_err),  64'd0);

    // Randomized runs against the scoreboard
    for (int r = 0; r < 8; r++) begin
      int n;
      n = int'($urandom_range(5, 60));
      for (int i = 0; i < n; i++) begin
        vv[i] = ($urandom_range(0, 3) != 0);
        ee[i] = ($urandom_range(0, 9) == 0) ? NAR : 32'($urandom);
        case ($urandom_range(0, 19))
          0:       rr[i] = NAR;
          1:       rr[i] = 32'h0;
          2, 3:    rr[i] = ee[i] + 32'($urandom_range(1, 255));
          4:       rr[i] = ee[i] - 32'($urandom_range(1, 255));
          default: rr[i] = ee[i];
        endcase
      end
      run_seq(n, L, 1'b0, $sformatf("rand%0d", r));
    end

    // Reset mid-RUN with 3 samples in flight and a protocol error pending
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.in_valid = 1'b1; bus.exp_value = $urandom; bus.dut_result = $urandom;
      bus.dut_done = (c == 0);
      tick();
    end
    bus.in_valid = 1'b0; bus.dut_done = 1'b0;
    chk("rst pre busy",      64'(bus.busy),      64'd1);
    chk("rst pre proto_err", 64'(bus.proto_err), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("postrst diff_valid k%0d", k), 64'(bus.diff_valid), 64'd0);
      chk($sformatf("postrst busy k%0d", k),       64'(bus.busy),       64'd0);
      bus.dut_done = (k < 3); bus.dut_result = $urandom;
      bus.in_valid = 1'b1;    bus.exp_value  = $urandom;
      tick();
    end
    bus.in_valid = 1'b0; bus.dut_done = 1'b0;
    chk("postrst diff_valid end", 64'(bus.diff_valid), 64'd0);
    chk("postrst sample_cnt",     64'(bus.sample_cnt), 64'd0);
    chk("postrst proto_err",      64'(bus.proto_err),  64'd0);
    chk("postrst fail",           64'(bus.fail),       64'd0);
    chk("postrst finished",       64'(bus.finished),   64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

`default_nettype wire
